spi_reg_controller: RTL and testbench
=====================================

# spi_reg_controller

Register-access controller sequencing byte transfers of the SPI byte reader. Decodes a command byte, then performs register writes or loads read data into the reader's transmit byte for each following byte, optionally auto-incrementing the address. Owns a small 8-bit register file whose contents drive the rest of the design, with a status read-back path.

## Interface
- NUM_REGS, 16, number of 8-bit registers (2..16); address 0 is read-only ID
- DEVICE_ID, 8'h4D, value returned when reading address 0
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- spi_cs_n  input  1  chip select, already synchronised to clk; high = no frame
- rx_data  input  8  byte from the SPI reader (`data`)
- rx_valid  input  1  one-cycle pulse: rx_data holds a new complete byte (`received`)
- tx_data  output  8  byte for the reader to shift out next (`toOutput`)
- regs  output  NUM_REGS*8  flat register file, reg n at bits [8n+7:8n]; reg 0 slice = DEVICE_ID
- wr_strobe  output  1  one-cycle pulse on each accepted register write
- wr_addr  output  4  address of the write flagged by wr_strobe
- err  output  1  one-cycle pulse on access to an address >= NUM_REGS

## Operation
- Command byte: bit7 = 1 write / 0 read; bits6:4 ignored; bits3:0 start address.
- States: IDLE, WRITE, READ.
- IDLE: rx_valid with spi_cs_n low latches command; bit7=1 -> WRITE, else -> READ; address register <= bits3:0.
- WRITE: each rx_valid writes rx_data to regs[addr] if 1 <= addr < NUM_REGS and pulses wr_strobe/wr_addr; addr 0 ignored silently (no strobe, no err); addr >= NUM_REGS ignored, err pulses. Then address advances.
- READ: on entry and after each rx_valid, tx_data <= value at current address (DEVICE_ID for 0, regs[addr] for valid, 8'hFF and err pulse for invalid). Each rx_valid in READ (byte clocked out, received byte discarded) advances address, and tx_data is reloaded.
- Address advance: 4-bit increment, wraps 15 -> 0.
- spi_cs_n high in any state: return to IDLE next clk, tx_data <= 8'h00; an in-flight rx_valid coincident with spi_cs_n high is ignored.
- rx_valid while spi_cs_n high: ignored entirely.
- Register contents persist across frames; only rst clears them.

## Timing
- Reset: state IDLE, address 0, tx_data 8'h00, all registers (1..NUM_REGS-1) 8'h00, wr_strobe 0, wr_addr 0, err 0.
- Write: regs and wr_strobe update on the clk edge after the rx_valid cycle (1-cycle latency).
- Read: tx_data valid 1 clk after the command rx_valid, and 1 clk after every subsequent rx_valid in READ.
- Caller guarantees at least 4 clk between rx_valid pulses and between last rx_valid and the next byte's first spi_clk edge; tx_data is then stable before the reader samples it.
- Frame: first byte's tx_data is 8'h00 (command phase); read data starts with byte 2.
- Reset asserted mid-frame: immediate return to reset values regardless of spi_cs_n.

## Configuration
- SPI_REG_AUTOINC_EN defined: address advances after each data byte (burst access) as described.
- Not defined: address stays fixed at the command address for the whole frame; repeated writes overwrite the same register, repeated reads return the same register.

## Test plan
- Reset: assert rst, check tx_data=8'h00, all regs 8'h00, no strobes; release, still idle.
- Single write: cs low, bytes 8'h83, 8'h5A -> regs[3]=8'h5A, one wr_strobe with wr_addr=3, err never set; cs high.
- Burst read (AUTOINC on): preload regs[1]=8'h11, regs[2]=8'h22; frame 8'h01, x, x -> tx_data sequence 8'h00, 8'h11, 8'h22 on bytes 1-3; reading 8'h00 returns 8'h4D.
- Boundary: NUM_REGS=4, frame 8'h82, 8'hAA, 8'hBB, 8'hCC -> regs[2]=8'hAA, regs[3]=8'hBB, third data byte ignored with err pulse; read of addr 5 returns 8'hFF with err.
- Wrap: NUM_REGS=16, frame 8'h8F, 8'h01, 8'h02 -> regs[15]=8'h01, addr wraps to 0, second write ignored, no err, reg 0 still reads 8'h4D.
- Abort: raise spi_cs_n after command 8'h84 before data; next frame 8'h85, 8'h77 -> regs[5]=8'h77, regs[4] unchanged; AUTOINC off build: 8'h86, 8'h01, 8'h02 -> regs[6]=8'h02, regs[7] unchanged.

Source files
------------

// File: rtl/spi_reg_controller_if.sv
// Byte-level link between the SPI byte reader and the register controller.
// The reader side drives frame/byte strobes; the controller returns the next tx byte.
interface spi_reg_controller_if;
  logic       spi_cs_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;

  modport master (
    output spi_cs_n, rx_data, rx_valid,
    input  tx_data
  );

  modport slave (
    input  spi_cs_n, rx_data, rx_valid,
    output tx_data
  );
endinterface

// File: rtl/spi_reg_controller.sv
// Command-decoding register file behind the SPI byte reader.
// Define SPI_REG_AUTOINC_EN to advance the address after every data byte.
module spi_reg_controller #(
  parameter int         NUM_REGS  = 16,
  parameter logic [7:0] DEVICE_ID = 8'h4D
) (
  input  logic                    clk,
  input  logic                    rst,
  spi_reg_controller_if.slave     bus,
  output logic [NUM_REGS*8-1:0]   regs,
  output logic                    wr_strobe,
  output logic [3:0]              wr_addr,
  output logic                    err
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          addr_q, addr_d;
  logic [7:0]          tx_q, tx_d;
  logic                we_d, err_d;
  logic [3:0]          next_addr;
  logic [3:0]          rd_addr;
  logic [7:0]          rd_data;
  logic                rd_bad;
  logic                addr_ok;
  logic [NUM_REGS*8-1:8] data_q;

  function automatic logic in_range(input logic [3:0] a);
    return int'(a) < NUM_REGS;
  endfunction

`ifdef SPI_REG_AUTOINC_EN
  assign next_addr = addr_q + 4'd1;
`else
  assign next_addr = addr_q;
`endif

  assign regs        = {data_q, DEVICE_ID};
  assign bus.tx_data = tx_q;
  assign addr_ok     = in_range(addr_q);

  // Read target: command address while idle, upcoming address otherwise.
  assign rd_addr = (state_q == IDLE) ? bus.rx_data[3:0] : next_addr;
  assign rd_bad  = !in_range(rd_addr);

  always_comb begin
    rd_data = 8'hFF;
    if (rd_addr == 4'd0)
      rd_data = DEVICE_ID;
    else if (!rd_bad)
      rd_data = regs[8*int'(rd_addr) +: 8];
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tx_d    = tx_q;
    we_d    = 1'b0;
    err_d   = 1'b0;
    if (bus.spi_cs_n) begin
      state_d = IDLE;
      tx_d    = 8'h00;
    end else if (bus.rx_valid) begin
      unique case (state_q)
        IDLE: begin
          addr_d = bus.rx_data[3:0];
          if (bus.rx_data[7]) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
            tx_d    = rd_data;
            err_d   = rd_bad;
          end
        end
        WRITE: begin
          addr_d = next_addr;
          if (!addr_ok)
            err_d = 1'b1;
          else if (addr_q != 4'd0)
            we_d = 1'b1;
        end
        READ: begin
          addr_d = next_addr;
          tx_d   = rd_data;
          err_d  = rd_bad;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= 4'd0;
      tx_q      <= 8'h00;
      wr_strobe <= 1'b0;
      wr_addr   <= 4'd0;
      err       <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      tx_q      <= tx_d;
      wr_strobe <= we_d;
      err       <= err_d;
      if (we_d) begin
        wr_addr <= addr_q;
        data_q[8*int'(addr_q) +: 8] <= bus.rx_data;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_controller.sv
// Drives a 16-register and a 4-register controller with identical byte
// streams and compares both against a frame-level reference model.
module tb_spi_reg_controller;

`ifdef SPI_REG_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic cs_n;
  logic [7:0] rxd;
  logic rxv;

  always #5 clk = ~clk;

  spi_reg_controller_if b16 ();
  spi_reg_controller_if b4 ();

  assign b16.spi_cs_n = cs_n;
  assign b16.rx_data  = rxd;
  assign b16.rx_valid = rxv;
  assign b4.spi_cs_n  = cs_n;
  assign b4.rx_data   = rxd;
  assign b4.rx_valid  = rxv;

  logic [127:0] r16;
  logic [31:0]  r4;
  logic         we16, we4, err16, err4;
  logic [3:0]   wa16, wa4;

  spi_reg_controller #(.NUM_REGS(16), .DEVICE_ID(8'h4D)) d16 (
    .clk(clk), .rst(rst), .bus(b16.slave), .regs(r16),
    .wr_strobe(we16), .wr_addr(wa16), .err(err16)
  );

  spi_reg_controller #(.NUM_REGS(4), .DEVICE_ID(8'h4D)) d4 (
    .clk(clk), .rst(rst), .bus(b4.slave), .regs(r4),
    .wr_strobe(we4), .wr_addr(wa4), .err(err4)
  );

  logic [7:0]   tx_o   [2];
  logic         we_o   [2];
  logic         err_o  [2];
  logic [3:0]   wa_o   [2];
  logic [127:0] regs_o [2];

  assign tx_o[0]   = b16.tx_data;
  assign tx_o[1]   = b4.tx_data;
  assign we_o[0]   = we16;
  assign we_o[1]   = we4;
  assign err_o[0]  = err16;
  assign err_o[1]  = err4;
  assign wa_o[0]   = wa16;
  assign wa_o[1]   = wa4;
  assign regs_o[0] = r16;
  assign regs_o[1] = {96'd0, r4};

  int tests = 0;
  int fails = 0;

  int         nr [2] = '{16, 4};
  logic [7:0] mreg [2][16];
  logic [7:0] cmd;
  int         idx;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mval(input int k, input int a);
    if (a == 0) return 8'h4D;
    if (a >= nr[k]) return 8'hFF;
    return mreg[k][a];
  endfunction

  function automatic logic [127:0] mflat(input int k);
    logic [127:0] r = '0;
    for (int i = 0; i < nr[k]; i++)
      r[8*i +: 8] = (i == 0) ? 8'h4D : mreg[k][i];
    return r;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++)
        mreg[k][i] = 8'h00;
  endtask

  task automatic check_idle(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.tx%0d", tag, k), 128'(tx_o[k]), 128'h00);
      chk($sformatf("%s.we%0d", tag, k), 128'(we_o[k]), 128'h0);
      chk($sformatf("%s.err%0d", tag, k), 128'(err_o[k]), 128'h0);
      chk($sformatf("%s.regs%0d", tag, k), regs_o[k], mflat(k));
    end
  endtask

  task automatic start_frame();
    @(negedge clk);
    cs_n = 1'b0;
    idx  = -1;
    repeat (2) @(negedge clk);
  endtask

  task automatic end_frame(input string tag);
    @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle(tag);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [7:0] etx;
    logic       ewe, eerr;
    int         a;
    @(negedge clk);
    rxd = b;
    rxv = 1'b1;
    @(posedge clk);
    #1;
    if (idx < 0) begin
      cmd = b;
      idx = 0;
    end else begin
      idx++;
    end
    for (int k = 0; k < 2; k++) begin
      ewe  = 1'b0;
      eerr = 1'b0;
      etx  = 8'h00;
      a    = int'(cmd[3:0]);
      if (idx == 0) begin
        if (!cmd[7]) begin
          etx  = mval(k, a);
          eerr = (a >= nr[k]);
        end
      end else if (cmd[7]) begin
        if (AUTOINC) a = (a + idx - 1) % 16;
        ewe  = (a != 0) && (a < nr[k]);
        eerr = (a >= nr[k]);
        if (ewe) mreg[k][a] = b;
      end else begin
        if (AUTOINC) a = (a + idx) % 16;
        etx  = mval(k, a);
        eerr = (a >= nr[k]);
      end
      chk($sformatf("b%0d.tx%0d", idx, k), 128'(tx_o[k]), 128'(etx));
      chk($sformatf("b%0d.we%0d", idx, k), 128'(we_o[k]), 128'(ewe));
      chk($sformatf("b%0d.err%0d", idx, k), 128'(err_o[k]), 128'(eerr));
      if (ewe)
        chk($sformatf("b%0d.wa%0d", idx, k), 128'(wa_o[k]), 128'(a));
      chk($sformatf("b%0d.regs%0d", idx, k), regs_o[k], mflat(k));
    end
    @(negedge clk);
    rxv = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("pulse.we%0d", k), 128'(we_o[k]), 128'h0);
      chk($sformatf("pulse.err%0d", k), 128'(err_o[k]), 128'h0);
    end
  endtask

  // rx_valid arriving together with a deasserted chip select.
  task automatic stray_byte(input logic [7:0] b);
    @(negedge clk);
    cs_n = 1'b1;
    rxd  = b;
    rxv  = 1'b1;
    @(posedge clk);
    #1;
    check_idle("stray");
    @(negedge clk);
    rxv = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int len;
    rst  = 1'b1;
    cs_n = 1'b1;
    rxv  = 1'b0;
    rxd  = 8'h00;
    idx  = -1;
    cmd  = 8'h00;
    model_clear();
    repeat (3) @(negedge clk);
    check_idle("reset");
    for (int k = 0; k < 2; k++)
      chk($sformatf("reset.wa%0d", k), 128'(wa_o[k]), 128'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("post_reset");

    // single write
    start_frame();
    send_byte(8'h83);
    send_byte(8'h5A);
    end_frame("single_wr");
    chk("single_wr.r3", 128'(r16[31:24]), 128'h5A);

    // preload then burst read; also read the ID register
    start_frame(); send_byte(8'h81); send_byte(8'h11); end_frame("pre1");
    start_frame(); send_byte(8'h82); send_byte(8'h22); end_frame("pre2");
    start_frame();
    send_byte(8'h01);
    send_byte(8'hC3);
    send_byte(8'h3C);
    end_frame("burst_rd");
    start_frame(); send_byte(8'h00); send_byte(8'h00); end_frame("id_rd");

    // boundary: burst past the top of the small file, invalid read
    start_frame();
    send_byte(8'h82);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    end_frame("boundary_wr");
    start_frame(); send_byte(8'h05); send_byte(8'h00); end_frame("bad_rd");

    // wrap from 15 to 0
    start_frame();
    send_byte(8'h8F);
    send_byte(8'h01);
    send_byte(8'h02);
    end_frame("wrap_wr");
    start_frame(); send_byte(8'h0F); send_byte(8'h00); end_frame("wrap_rd");

    // abort after command, then fresh frames
    start_frame(); send_byte(8'h84); end_frame("abort");
    start_frame(); send_byte(8'h85); send_byte(8'h77); end_frame("after_abort");
    start_frame();
    send_byte(8'h86);
    send_byte(8'h01);
    send_byte(8'h02);
    end_frame("fixed_or_burst");

    // bytes while deselected, including one coincident with deselect
    stray_byte(8'h99);
    start_frame();
    send_byte(8'h81);
    stray_byte(8'hEE);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      start_frame();
      len = $urandom_range(0, 5);
      for (int i = 0; i <= len; i++)
        send_byte(8'($urandom));
      end_frame($sformatf("rand%0d", f));
      if (($urandom % 8) == 0) stray_byte(8'($urandom));
    end

    // reset mid-frame
    start_frame();
    send_byte(8'h01);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_clear();
    check_idle("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    end_frame("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
